cla_serial_adder: RTL and testbench

Multi-cycle carry-lookahead adder for the datapath. It adds two WIDTH-bit operands one GROUP-bit slice per clock. Each slice forms bitwise propagate/generate and lookahead carries, the same p/g/sum formulation as the team's partial full adder cell. A ripple register links the group carries between slices. Operands arrive and results leave on valid/ready handshakes, so the block sits between the operand-issue stage and the writeback stage.

---
 rtl/cla_pkg.sv | 40 ++++
 rtl/cla_group.sv | 52 +++++
 rtl/cla_serial_adder.sv | 159 +++++++++++++++
 tb/tb_cla_serial_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder.
//
// Contents:
//   cla_state_e   - FSM state encoding (IDLE, RUN, DONE)
//   CLA_WIDTH     - default operand width
//   CLA_GROUP     - default bits resolved per cycle
//   CLA_N         - default slice count (CLA_WIDTH / CLA_GROUP)
//   CLA_KW        - default slice-index width, $clog2(CLA_N) with a floor of 1
//   cla_cfg_ok()  - elaboration check that width is a multiple of the group size
//   cla_slices()  - slice count for a given width / group
//   cla_idx_w()   - slice-index width for a given slice count
//
// Optional feature macro used by the top: CLA_SUB_EN (subtract support).
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_e;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 4;
  localparam int CLA_N     = CLA_WIDTH / CLA_GROUP;
  // A single-slice build still needs a 1-bit index register.
  localparam int CLA_KW    = (CLA_N > 1) ? $clog2(CLA_N) : 1;

  function automatic bit cla_cfg_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

  function automatic int cla_slices(input int width, input int group);
    return width / group;
  endfunction

  function automatic int cla_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
//
// Every carry inside the slice is formed from the slice carry-in through
// prefix propagate/generate terms, so no carry waits on its neighbour.
//
// Ports:
//   a, b      in   GROUP  operand slice
//   c_in      in   1      carry into the slice LSB
//   sum       out  GROUP  slice sum, sum_i = p_i ^ c_i
//   c_out     out  1      carry out of the slice MSB
//   c_msb_in  out  1      carry into the slice MSB (for signed overflow)
//   p_grp     out  1      group propagate (all bits propagate)
//   g_grp     out  1      group generate (slice generates a carry by itself)
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] sum,
  output logic             c_out,
  output logic             c_msb_in,
  output logic             p_grp,
  output logic             g_grp
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] c;      // carry into each bit
  logic             pp;     // prefix propagate over bits below i
  logic             gg;     // prefix generate over bits below i

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c  = '0;
    pp = 1'b1;
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      // Carry into bit i depends only on prefix terms and c_in.
      c[i] = gg | (pp & c_in);
      gg   = g[i] | (p[i] & gg);
      pp   = pp & p[i];
    end
    p_grp    = pp;
    g_grp    = gg;
    c_out    = gg | (pp & c_in);
    c_msb_in = c[GROUP-1];
    sum      = p ^ c;
  end

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle carry-lookahead adder: resolves one GROUP-bit slice per clock,
// linking slices through a registered carry.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE, and sum/cout/overflow hold stable while out_valid && !out_ready.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a, b, cin (and sub) are valid
//   in_ready   out  1      operands accepted (IDLE only)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in
//   sub        in   1      subtract select (only when CLA_SUB_EN is defined)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of the MSB (1 = no borrow when subtracting)
//   overflow   out  1      signed overflow, carry into MSB ^ carry out of MSB
//
// Optional feature macro: CLA_SUB_EN adds the sub port. With sub=1 the block
// latches ~b and forces the initial carry to 1, ignoring cin.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = cla_slices(WIDTH, GROUP);
  localparam int KW = cla_idx_w(N);
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  if (!cla_cfg_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("cla_serial_adder: WIDTH must be a positive multiple of GROUP");
  end

  cla_state_e       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;

  // Operand B and initial carry as they are latched at acceptance.
  logic [WIDTH-1:0] b_eff;
  logic             c_init;

`ifdef CLA_SUB_EN
  always_comb begin
    b_eff  = sub ? ~b : b;
    c_init = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_eff  = b;
    c_init = cin;
  end
`endif

  logic [GROUP-1:0] g_sum;
  logic             g_cout;
  logic             g_cmsb;
  logic             g_p;
  logic             g_g;

  // Operand registers shift right one slice per RUN cycle, so the current
  // slice always sits in the low GROUP bits.
  cla_group #(.GROUP(GROUP)) u_group (
    .a        (a_q[GROUP-1:0]),
    .b        (b_q[GROUP-1:0]),
    .c_in     (carry_q),
    .sum      (g_sum),
    .c_out    (g_cout),
    .c_msb_in (g_cmsb),
    .p_grp    (g_p),
    .g_grp    (g_g)
  );

  // Group P/G are not needed by the serial datapath; kept for observability.
  logic unused_pg;
  assign unused_pg = g_p ^ g_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      k         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is a transfer.
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b_eff;
            carry_q  <= c_init;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> GROUP;
          b_q     <= b_q >> GROUP;
          carry_q <= g_cout;
          // Slice sums enter at the top; after N slices they are aligned.
          sum     <= (sum >> GROUP) | (WIDTH'(g_sum) << (WIDTH - GROUP));
          if (k == LAST) begin
            cout      <= g_cout;
            overflow  <= g_cmsb ^ g_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder (default WIDTH=32, GROUP=4).
// Build with +define+CLA_SUB_EN to include the subtract vectors.
module tb_cla_serial_adder;

  localparam int W   = 32;
  localparam int N   = 8;
  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef CLA_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  cla_serial_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Runs one full operation: accept, wait for result, check, output handshake.
  task automatic run_op(input vec_t v, input string tag);
    int cnt;
    logic [W-1:0] e;
    check({tag, " in_ready before accept"}, W'(in_ready), W'(1));
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
`ifdef CLA_SUB_EN
    sub      = v.sub;
`endif
    in_valid = 1'b1;
    exp_q.push_back(v.exp_sum);
    tick();
    in_valid = 1'b0;
    // Operands may change freely once accepted.
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
`ifdef CLA_SUB_EN
    sub = 1'($urandom_range(0, 1));
`endif
    check({tag, " in_ready after accept"}, W'(in_ready), W'(0));
    cnt = 0;
    while (!out_valid && cnt < TMO) begin
      tick();
      cnt++;
    end
    check({tag, " latency"}, W'(cnt), W'(N));
    e = exp_q.pop_front();
    check({tag, " sum"}, sum, e);
    check({tag, " cout"}, W'(cout), W'(v.exp_cout));
    check({tag, " overflow"}, W'(overflow), W'(v.exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, W'(out_valid), W'(0));
    check({tag, " in_ready after handshake"}, W'(in_ready), W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    vec_t v;

    // a, b, cin, sub, exp_sum, exp_cout, exp_ovf
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
`ifdef CLA_SUB_EN
    // cin is ignored when subtracting.
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
`endif

    // ---- reset, with in_valid asserted (reset wins) ----
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 32'hDEAD_BEEF;
    b         = 32'h1234_5678;
    cin       = 1'b1;
`ifdef CLA_SUB_EN
    sub       = 1'b0;
`endif
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset sum", sum, '0);
    check("reset cout", W'(cout), W'(0));
    check("reset overflow", W'(overflow), W'(0));
    tick();
    check("reset idle hold in_ready", W'(in_ready), W'(1));

    // ---- table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- backpressure in DONE with in_valid pulsed ----
    v = vecs[1];
    a = v.a; b = v.b; cin = v.cin;
`ifdef CLA_SUB_EN
    sub = 1'b0;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < TMO) begin
      tick();
      cnt++;
    end
    check("bp latency", W'(cnt), W'(N));
    for (int c = 0; c < 5; c++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      in_valid = (c % 2 == 0);
      tick();
      check($sformatf("bp c%0d out_valid", c), W'(out_valid), W'(1));
      check($sformatf("bp c%0d in_ready", c), W'(in_ready), W'(0));
      check($sformatf("bp c%0d sum", c), sum, v.exp_sum);
      check($sformatf("bp c%0d cout", c), W'(cout), W'(v.exp_cout));
      check($sformatf("bp c%0d overflow", c), W'(overflow), W'(v.exp_ovf));
    end
    // in_valid still high across the output handshake: must not be taken.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp in_ready after handshake", W'(in_ready), W'(1));
    check("bp out_valid after handshake", W'(out_valid), W'(0));
    tick();
    check("bp no re-accept in_ready", W'(in_ready), W'(1));

    // ---- reset on the 4th RUN cycle ----
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("midrst in RUN in_ready", W'(in_ready), W'(0));
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst out_valid", W'(out_valid), W'(0));
    check("midrst in_ready", W'(in_ready), W'(1));
    check("midrst sum", sum, '0);
    check("midrst cout", W'(cout), W'(0));
    check("midrst overflow", W'(overflow), W'(0));
    cnt = 0;
    for (int c = 0; c < N + 2; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("midrst no partial valid", W'(cnt), W'(0));
    run_op(vecs[0], "after midrst");

    // ---- reset while DONE ----
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < TMO) begin
      tick();
      cnt++;
    end
    check("donerst latency", W'(cnt), W'(N));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("donerst out_valid", W'(out_valid), W'(0));
    check("donerst in_ready", W'(in_ready), W'(1));
    check("donerst sum", sum, '0);
    check("donerst overflow", W'(overflow), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
